// File: rtl/adc_serial_rd_pkg.sv
// Shared definitions for the serial ADC reader.
// Holds the FSM state encoding, the default timing constants for a 50 MHz
// system clock, and the widths used by the reader and its averager.
package adc_serial_rd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StConv
  } adc_state_e;

  // Default timing in clk_i cycles at 50 MHz.
  localparam int unsigned SclkHalfDefault = 25;
  localparam int unsigned CsSetupDefault  = 75;
  localparam int unsigned ConvWaitDefault = 1000;

  // Largest legal timing parameter sets the shared counter width.
  localparam int unsigned ConvWaitMax = 65535;
  localparam int unsigned CntW        = $clog2(ConvWaitMax + 1);

  localparam int unsigned SampleW = 8;
  localparam int unsigned NumBits = 8;
  localparam int unsigned SumW    = SampleW + 2;

endpackage

// File: rtl/adc_avg4.sv
// Four-tap moving averager.
// Keeps the last four samples and a running sum; each load adds the new
// sample and drops the oldest. History starts at zero after reset, so the
// output ramps up over the first samples.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   load_i        accept din_i this cycle
//   din_i         new sample
//   dout_o        mean of the last four samples (sum / 4, truncated)
module adc_avg4
  import adc_serial_rd_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [SampleW-1:0] din_i,
  output logic [SampleW-1:0] dout_o
);

  logic [SampleW-1:0] hist_q [4];
  logic [SampleW-1:0] hist_d [4];
  logic [SumW-1:0]    sum_q, sum_d;

  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    if (load_i) begin
      // Result always fits in SumW bits, so modular arithmetic is exact.
      sum_d = sum_q + {2'b00, din_i} - {2'b00, hist_q[3]};
      hist_d[0] = din_i;
      for (int i = 1; i < 4; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '{default: '0};
      sum_q  <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  assign dout_o = sum_q[SumW-1:2];

endmodule

// File: rtl/adc_serial_rd.sv
// Continuous serial ADC reader with 4-sample moving average.
// Frames: drop chip select, wait CS_SETUP cycles, clock in 8 bits MSB first
// (sampled on sclk rise), hold one cycle, raise chip select and publish the
// sample, then keep chip select high for CONV_WAIT cycles of conversion.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   en_i           1 = keep acquiring; 0 = stop after the current frame
//   adc_sdo_i      serial data from the ADC
//   adc_cs_n_o     chip select, active low
//   adc_sclk_o     serial clock, idle low
//   adc_raw_o      latest raw sample
//   adc_val_o      mean of the last four samples
//   adc_valid_o    one-cycle pulse, one cycle after raw/val update
module adc_serial_rd
  import adc_serial_rd_pkg::*;
#(
  parameter int unsigned SCLK_HALF = SclkHalfDefault,
  parameter int unsigned CS_SETUP  = CsSetupDefault,
  parameter int unsigned CONV_WAIT = ConvWaitDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               adc_sdo_i,
  output logic               adc_cs_n_o,
  output logic               adc_sclk_o,
  output logic [SampleW-1:0] adc_raw_o,
  output logic [SampleW-1:0] adc_val_o,
  output logic               adc_valid_o
);

  localparam logic [CntW-1:0] SclkLast  = CntW'(SCLK_HALF - 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP - 1);
  localparam logic [CntW-1:0] ConvLast  = CntW'(CONV_WAIT - 1);
  // After reset the IDLE cycle itself counts as the first conversion cycle.
  localparam logic [CntW-1:0] ConvFirst = (CONV_WAIT > 1) ? CntW'(1) : '0;
  localparam logic [2:0]      BitLast   = 3'(NumBits - 1);

  adc_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [SampleW-1:0] shreg_q, shreg_d;
  logic [SampleW-1:0] raw_q, raw_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               conv_pend_q, conv_pend_d;
  logic               load_q, valid_q;
  logic               frame_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    conv_pend_d = conv_pend_q;
    frame_done  = 1'b0;

    case (state_q)
      StIdle: begin
        if (conv_pend_q) begin
          // Give the ADC a full conversion time before the first frame.
          state_d     = StConv;
          cnt_d       = ConvFirst;
          conv_pend_d = 1'b0;
        end else if (en_i) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StShift: begin
        if (cnt_q == SclkLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[SampleW-2:0], adc_sdo_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BitLast) begin
              state_d = StHold;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHold: begin
        state_d    = StConv;
        cs_n_d     = 1'b1;
        cnt_d      = '0;
        frame_done = 1'b1;
      end

      StConv: begin
        if (cnt_q >= ConvLast) begin
          cnt_d = '0;
          if (en_i) begin
            state_d = StSetup;
            cs_n_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    raw_d = raw_q;
    if (frame_done) begin
      raw_d = shreg_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      raw_q       <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      conv_pend_q <= 1'b1;
      load_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      raw_q       <= raw_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      conv_pend_q <= conv_pend_d;
      load_q      <= frame_done;
      // Valid trails the data update by one cycle.
      valid_q     <= load_q;
    end
  end

  adc_avg4 u_avg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (frame_done),
    .din_i  (shreg_q),
    .dout_o (adc_val_o)
  );

  assign adc_cs_n_o  = cs_n_q;
  assign adc_sclk_o  = sclk_q;
  assign adc_raw_o   = raw_q;
  assign adc_valid_o = valid_q;

endmodule

// File: tb/tb_adc_serial_rd.sv
// Bench for adc_serial_rd: behavioural ADC, timing checker, and a
// scoreboard fed by the stimulus with expected (raw, mean) pairs.
module tb_adc_serial_rd;

  localparam int unsigned SclkHalf = 2;
  localparam int unsigned CsSetup  = 4;
  localparam int unsigned ConvWait = 10;
  localparam int unsigned Bits     = 8;
  localparam int          Budget   = 5000;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b0;
  logic       adc_sdo = 1'b0;
  logic       cs_n, sclk, valid;
  logic [7:0] raw, val;

  always #5 clk = ~clk;

  adc_serial_rd #(
    .SCLK_HALF (SclkHalf),
    .CS_SETUP  (CsSetup),
    .CONV_WAIT (ConvWait)
  ) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .adc_sdo_i   (adc_sdo),
    .adc_cs_n_o  (cs_n),
    .adc_sclk_o  (sclk),
    .adc_raw_o   (raw),
    .adc_val_o   (val),
    .adc_valid_o (valid)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  adc_q[$];
  logic [15:0] exp_q[$];
  int unsigned mdl_hist[$];

  int frames_started = 0;
  int rises_in_frame = 0;
  int valid_cnt = 0;
  int sclk_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: mean of the last four words, missing entries are zero.
  function automatic int unsigned mdl_sum();
    int unsigned s = 0;
    foreach (mdl_hist[i]) s += mdl_hist[i];
    return s;
  endfunction

  task automatic push_frame(input logic [7:0] w);
    adc_q.push_back(w);
    mdl_hist.push_front(int'(w));
    if (mdl_hist.size() > 4) void'(mdl_hist.pop_back());
    exp_q.push_back({w, 8'(mdl_sum() / 4)});
  endtask

  // ADC model and interface timing checker.
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [7:0] word = 8'h00;
  int         bit_idx = 0;
  longint     cyc = 0, fall_cyc = 0, last_rise = 0;
  int         hi_len = 0;
  bit         hi_en_all = 1'b1, hi_rst = 1'b1, frame_rst = 1'b1;

  initial begin : adc_model
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i) begin
        frame_rst = 1'b1;
        hi_rst    = 1'b1;
      end
      if (cs_n && sclk) sclk_bad++;
      if (cs_n) begin
        hi_len++;
        if (!en_i) hi_en_all = 1'b0;
      end
      if (prev_cs && !cs_n) begin
        if (!hi_rst) begin
          if (hi_en_all) check("conv_wait", hi_len, ConvWait);
          else check("conv_wait_min", longint'(hi_len >= ConvWait), 1);
        end
        hi_len = 0;
        hi_en_all = 1'b1;
        hi_rst = 1'b0;
        frame_rst = 1'b0;
        if (adc_q.size() != 0) word = adc_q.pop_front();
        else word = 8'($urandom);
        bit_idx = 7;
        adc_sdo = word[7];
        frames_started++;
        rises_in_frame = 0;
        fall_cyc = cyc;
      end else if (!cs_n && prev_sclk && !sclk && bit_idx > 0) begin
        bit_idx--;
        adc_sdo = word[bit_idx];
      end
      if (!prev_sclk && sclk && !cs_n) begin
        rises_in_frame++;
        if (rises_in_frame == 1) check("cs_to_first_rise", cyc - fall_cyc, CsSetup + SclkHalf);
        else check("rise_spacing", cyc - last_rise, 2 * SclkHalf);
        last_rise = cyc;
      end
      if (!prev_cs && cs_n && !frame_rst) check("rises_per_frame", rises_in_frame, Bits);
      prev_cs = cs_n;
      prev_sclk = sclk;
    end
  end

  // Scoreboard monitor.
  logic        mon_prev_valid = 1'b0;
  logic        mon_cs_d1 = 1'b1, mon_cs_d2 = 1'b1;
  logic [15:0] mon_exp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (valid) begin
        valid_cnt++;
        check("valid_width", mon_prev_valid, 0);
        check("valid_after_cs_rise", {mon_cs_d2, mon_cs_d1}, 2'b01);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: raw=0x%0h val=0x%0h, expected no pulse", raw, val);
        end else begin
          mon_exp = exp_q.pop_front();
          check("raw", raw, mon_exp[15:8]);
          check("val", val, mon_exp[7:0]);
        end
      end
      mon_prev_valid = valid;
      mon_cs_d2 = mon_cs_d1;
      mon_cs_d1 = cs_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    en_i  = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    mdl_hist.delete();
  endtask

  task automatic wait_valid(input int v0, input string name);
    int t = 0;
    while (valid_cnt <= v0 && t < Budget) begin
      tick();
      t++;
    end
    check(name, longint'(t < Budget), 1);
  endtask

  task automatic wait_frame_bit(input int f0, input int nrise, input string name);
    int t = 0;
    while ((frames_started <= f0 || rises_in_frame < nrise) && t < Budget) begin
      tick();
      t++;
    end
    check(name, longint'(t < Budget), 1);
  endtask

  // Run n queued frames, dropping en_i during the last frame's setup.
  task automatic run_frames(input int n);
    int f0, v0, t;
    f0 = frames_started;
    v0 = valid_cnt;
    en_i = 1'b1;
    t = 0;
    while (frames_started < f0 + n && t < Budget) begin
      tick();
      t++;
    end
    en_i = 1'b0;
    while (valid_cnt < v0 + n && t < Budget) begin
      tick();
      t++;
    end
    check("frames_in_time", longint'(t < Budget), 1);
    repeat (ConvWait + 4) tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int v0, f0, n, bad, k;
    logic [7:0] w;
    logic [7:0] avg_words[5];

    // Reset state
    do_reset();
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_raw", raw, 0);
    check("rst_val", val, 0);
    check("rst_valid", valid, 0);
    check("rst_sum", u_dut.u_avg.sum_q, 0);

    // Single frame
    v0 = valid_cnt;
    push_frame(8'hA5);
    run_frames(1);
    check("single_valid_count", valid_cnt - v0, 1);
    check("single_raw", raw, 8'hA5);
    check("single_val", val, 8'h29);

    // Averaging ramp from a clean history
    do_reset();
    avg_words = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    foreach (avg_words[i]) push_frame(avg_words[i]);
    run_frames(5);
    check("avg_final_val", val, 8'h38);

    // Extremes
    for (int i = 0; i < 4; i++) push_frame(8'hFF);
    run_frames(4);
    check("max_val", val, 8'hFF);
    check("max_sum", u_dut.u_avg.sum_q, mdl_sum());
    for (int i = 0; i < 4; i++) push_frame(8'h00);
    run_frames(4);
    check("min_val", val, 8'h00);

    // en_i drop during bit 3: frame completes, then idle
    push_frame(8'($urandom));
    f0 = frames_started;
    v0 = valid_cnt;
    en_i = 1'b1;
    wait_frame_bit(f0, 3, "endrop_reach_bit3");
    en_i = 1'b0;
    wait_valid(v0, "endrop_frame_done");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!cs_n || sclk || valid) bad++;
    end
    check("endrop_idle_quiet", bad, 0);
    // From IDLE, chip select drops on the first enabled cycle
    push_frame(8'($urandom));
    v0 = valid_cnt;
    en_i = 1'b1;
    tick();
    check("idle_to_setup", cs_n, 0);
    en_i = 1'b0;
    wait_valid(v0, "idle_frame_done");
    repeat (ConvWait + 4) tick();

    // Reset mid-shift: aborted frame has no expectation
    adc_q.push_back(8'($urandom));
    f0 = frames_started;
    en_i = 1'b1;
    wait_frame_bit(f0, 5, "rst_reach_bit5");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    mdl_hist.delete();
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_raw", raw, 0);
    check("midrst_val", val, 0);
    check("midrst_valid", valid, 0);
    push_frame(8'($urandom));
    v0 = valid_cnt;
    n = 0;
    do begin
      @(negedge clk);
      if (cs_n) n++;
    end while (cs_n && n < 200);
    check("midrst_conv_wait", n, ConvWait);
    en_i = 1'b0;
    wait_valid(v0, "midrst_next_frame");
    repeat (ConvWait + 4) tick();

    // Randomized bursts
    for (int it = 0; it < 4; it++) begin
      k = int'($urandom_range(1, 3));
      for (int j = 0; j < k; j++) begin
        w = 8'($urandom);
        push_frame(w);
      end
      run_frames(k);
    end

    check("sclk_while_cs_high", sclk_bad, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("adc_q_drained", adc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_serial_rd.md
ADC_SERIAL_RD -- requirements
Module: adc_serial_rd

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SCLK_HALF, 25, clk_i cycles per adc_sclk_o half-period; legal range 2..255.
- CS_SETUP, 75, clk_i cycles from adc_cs_n_o falling to the first adc_sclk_o rise; legal range 1..1023.
- CONV_WAIT, 1000, clk_i cycles adc_cs_n_o stays high after a frame (conversion time); legal range 1..65535.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  1 = run continuous acquisition; 0 = stop after the current frame.
- adc_sdo_i  in  1  serial data from the ADC, MSB first.
- adc_cs_n_o  out  1  ADC chip select, active low.
- adc_sclk_o  out  1  ADC serial clock, idle low.
- adc_raw_o  out  8  most recent raw sample.
- adc_val_o  out  8  mean of the last 4 samples; drives adc_val of the wave ROM.
- adc_valid_o  out  1  one-cycle pulse when adc_raw_o and adc_val_o update.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and CONV.
REQ-004 IDLE SHALL go to SETUP on the first cycle en_i=1; adc_cs_n_o SHALL drop in that same transition cycle.
REQ-005 SETUP SHALL last exactly CS_SETUP cycles with adc_sclk_o=0, then go to SHIFT.
REQ-006 SHIFT SHALL produce exactly 8 sclk periods, each SCLK_HALF cycles low then SCLK_HALF cycles high, starting low.
REQ-007 adc_sdo_i SHALL be sampled on the clk_i edge where adc_sclk_o goes 0->1 and shifted into an 8-bit register MSB first.
REQ-008 After the 8th high half-period, adc_sclk_o SHALL return to 0 and the FSM SHALL enter HOLD for 1 cycle, with adc_cs_n_o still low.
REQ-009 On HOLD exit, adc_cs_n_o SHALL go high, adc_raw_o SHALL load the shift register, and adc_valid_o SHALL pulse for exactly 1 cycle, 1 cycle after the load into adc_raw_o.
REQ-010 CONV SHALL keep adc_cs_n_o high for exactly CONV_WAIT cycles, then go to SETUP if en_i=1, else to IDLE.
REQ-011 The averager SHALL keep a 4-entry sample history and a 10-bit running sum: sum <= sum + new - oldest.
REQ-012 adc_val_o SHALL equal sum[9:2] (truncated), updated in the same cycle as adc_raw_o.
REQ-013 For the first 3 samples after reset, the missing history entries SHALL be 0, so the output ramps up from 0 and is not seeded.
REQ-014 If en_i drops during SETUP, SHIFT or HOLD, the frame SHALL complete normally, including the update and the CONV wait.
REQ-015 A change of en_i during CONV SHALL only be sampled at CONV exit.
REQ-016 Counters SHALL be sized from the parameter maxima and SHALL never wrap within a state.

Reset
REQ-017 While rst_i=1 on a clk_i edge, the following SHALL hold:
- state = IDLE;
- adc_cs_n_o = 1;
- adc_sclk_o = 0;
- adc_raw_o, adc_val_o and the history = 0;
- sum = 0;
- adc_valid_o = 0;
- all counters = 0.
REQ-018 A reset asserted mid-frame SHALL abort the frame with no valid pulse; the next frame SHALL start from SETUP after a full CONV_WAIT.
REQ-019 After reset release, the block SHALL pass through CONV before the first SETUP, so the ADC sees a conversion time.

Structure
REQ-020 The shared DDS package SHALL hold the FSM state encoding and the default timing constants (SCLK_HALF, CS_SETUP and CONV_WAIT at 50 MHz).
REQ-021 The 4-tap moving averager SHALL be a separate sub-module, adc_avg4, with ports: din 8, load 1, dout 8.

Verification
REQ-022 Benches SHALL use SCLK_HALF=2, CS_SETUP=4, CONV_WAIT=10, and a behavioural ADC model that drives the next bit after each sclk fall.
REQ-023 The bench SHALL cover these scenarios:
- Single frame: model word 0xA5, en_i=1 -> 8 sclk rises, 4 cycles apart; adc_raw_o=0xA5; adc_val_o=0x29 (165/4); one valid pulse; cs_n high for 10 cycles.
- Averaging: words 0x10, 0x20, 0x30, 0x40, 0x50 -> adc_val_o = 0x04, 0x0C, 0x18, 0x28, 0x38.
- Extremes: four frames of 0xFF -> adc_val_o=0xFF and sum=0x3FC; then four frames of 0x00 -> adc_val_o=0x00.
- en_i drop: drop en_i during bit 3 -> the frame completes with its update, CONV runs 10 cycles, then IDLE; cs_n stays high and sclk stays low.
- Reset mid-SHIFT: assert rst_i at bit 5 -> next cycle cs_n=1, sclk=0, outputs 0, no valid pulse; after release, the first cs_n fall comes after 10 cycles.
- Timing check: cs_n fall to first sclk rise = 4+2 cycles; no sclk edge while cs_n=1.
